// File: rtl/ebr_arbiter.sv
// Two-port round-robin arbiter that shares one 256 x 16 EBR between two requesters,
// with a zero-fill sweep after reset or on command.
module ebr_arbiter #(
    parameter bit CLEAR_ON_RESET = 1'b1,
    parameter int ADDR_W         = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              clear_start,
    output logic              busy,
    input  logic              req0_valid,
    input  logic              req1_valid,
    output logic              req0_ready,
    output logic              req1_ready,
    input  logic              req0_we,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [15:0]       req0_wdata,
    input  logic [15:0]       req1_wdata,
    input  logic [15:0]       req0_mask_n,
    input  logic [15:0]       req1_mask_n,
    output logic              resp0_valid,
    output logic              resp1_valid,
    output logic [15:0]       resp0_rdata,
    output logic [15:0]       resp1_rdata,
    output logic [ADDR_W-1:0] ram_raddr,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [15:0]       ram_wdata,
    output logic [15:0]       ram_mask_n,
    output logic              ram_re,
    output logic              ram_we,
    input  logic [15:0]       ram_rdata
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_cnt;
    logic                r_ptr;
    logic                r_rd_id;
    logic                r_ram_re;
    logic                r_ram_we;
    logic [ADDR_W-1:0]   r_ram_raddr;
    logic [ADDR_W-1:0]   r_ram_waddr;
    logic [15:0]         r_ram_wdata;
    logic [15:0]         r_ram_mask_n;
    logic                r_resp0_valid;
    logic                r_resp1_valid;

    logic                w_grant0;
    logic                w_grant1;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [15:0]         w_sel_wdata;
    logic [15:0]         w_sel_mask_n;

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        w_grant0    = 1'b0;
        w_grant1    = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                busy = 1'b1;
                if (r_cnt == '1) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (clear_start) begin
                    w_state_nxt = ST_CLEAR;
                end else if (!RST) begin
                    // r_ptr == 0 gives requester 0 priority on contention
                    w_grant0 = req0_valid && (!req1_valid || !r_ptr);
                    w_grant1 = req1_valid && (!req0_valid || r_ptr);
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    assign w_sel_we     = w_grant1 ? req1_we     : req0_we;
    assign w_sel_addr   = w_grant1 ? req1_addr   : req0_addr;
    assign w_sel_wdata  = w_grant1 ? req1_wdata  : req0_wdata;
    assign w_sel_mask_n = w_grant1 ? req1_mask_n : req0_mask_n;

    // NOTE: all state below is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            r_cnt         <= '0;
            r_ptr         <= 1'b0;
            r_rd_id       <= 1'b0;
            r_ram_re      <= 1'b0;
            r_ram_we      <= 1'b0;
            r_ram_raddr   <= '0;
            r_ram_waddr   <= '0;
            r_ram_wdata   <= '0;
            r_ram_mask_n  <= '0;
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ram_re      <= 1'b0;
            r_ram_we      <= 1'b0;
            // data from a read issued last cycle is on ram_rdata next cycle
            r_resp0_valid <= r_ram_re && !r_rd_id;
            r_resp1_valid <= r_ram_re && r_rd_id;
            if (r_state == ST_CLEAR) begin
                r_ram_we     <= 1'b1;
                r_ram_waddr  <= r_cnt;
                r_ram_wdata  <= '0;
                r_ram_mask_n <= '0;
                r_cnt        <= r_cnt + 1'b1;
            end else if (w_grant0 || w_grant1) begin
                r_ptr   <= w_grant0;
                r_rd_id <= w_grant1;
                if (w_sel_we) begin
                    r_ram_we     <= 1'b1;
                    r_ram_waddr  <= w_sel_addr;
                    r_ram_wdata  <= w_sel_wdata;
                    r_ram_mask_n <= w_sel_mask_n;
                end else begin
                    r_ram_re    <= 1'b1;
                    r_ram_raddr <= w_sel_addr;
                end
            end
        end
    end

    assign req0_ready  = w_grant0;
    assign req1_ready  = w_grant1;
    assign ram_re      = r_ram_re;
    assign ram_we      = r_ram_we;
    assign ram_raddr   = r_ram_raddr;
    assign ram_waddr   = r_ram_waddr;
    assign ram_wdata   = r_ram_wdata;
    assign ram_mask_n  = r_ram_mask_n;
    assign resp0_valid = r_resp0_valid;
    assign resp1_valid = r_resp1_valid;
    assign resp0_rdata = ram_rdata;
    assign resp1_rdata = ram_rdata;

endmodule

// File: tb/tb_ebr_arbiter.sv
// Randomised bench for ebr_arbiter: an EBR behavioural model plus a transaction-level
// reference (shadow memory, grant pointer, response queue keyed by due cycle).
module tb_ebr_arbiter;

    localparam bit CLR_RST = 1'b1;

    typedef struct packed {
        logic        v;
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] mask_n;
    } req_t;

    typedef struct {
        int          due;
        bit          id;
        logic [15:0] data;
    } rsp_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        clear_start = 1'b0;
    logic        busy;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic        req0_we = 1'b0, req1_we = 1'b0;
    logic [7:0]  req0_addr = '0, req1_addr = '0;
    logic [15:0] req0_wdata = '0, req1_wdata = '0;
    logic [15:0] req0_mask_n = '0, req1_mask_n = '0;
    logic        resp0_valid, resp1_valid;
    logic [15:0] resp0_rdata, resp1_rdata;
    logic [7:0]  ram_raddr, ram_waddr;
    logic [15:0] ram_wdata, ram_mask_n;
    logic        ram_re, ram_we;
    logic [15:0] ram_rdata;

    ebr_arbiter #(.CLEAR_ON_RESET(CLR_RST), .ADDR_W(8)) dut (
        .CLK(CLK), .RST(RST), .clear_start(clear_start), .busy(busy),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_we(req0_we), .req1_we(req1_we),
        .req0_addr(req0_addr), .req1_addr(req1_addr),
        .req0_wdata(req0_wdata), .req1_wdata(req1_wdata),
        .req0_mask_n(req0_mask_n), .req1_mask_n(req1_mask_n),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
        .resp0_rdata(resp0_rdata), .resp1_rdata(resp1_rdata),
        .ram_raddr(ram_raddr), .ram_waddr(ram_waddr),
        .ram_wdata(ram_wdata), .ram_mask_n(ram_mask_n),
        .ram_re(ram_re), .ram_we(ram_we), .ram_rdata(ram_rdata)
    );

    always #5 CLK = ~CLK;

    // EBR model: synchronous read and masked write, data one cycle after RE
    logic [15:0] ebr [256];
    logic [15:0] ebr_q;
    always @(posedge CLK) begin
        if (ram_we) ebr[ram_waddr] <= (ebr[ram_waddr] & ram_mask_n) | (ram_wdata & ~ram_mask_n);
        if (ram_re) ebr_q <= ebr[ram_raddr];
    end
    assign ram_rdata = ebr_q;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Reference model state
    logic [15:0] sh [256];
    rsp_t        rq [$];
    bit          m_known = 1'b0;
    bit          m_clear = 1'b0;
    logic [7:0]  m_cnt = '0;
    bit          m_ptr = 1'b0;
    bit          e_we = 1'b0, e_re = 1'b0, e_zero = 1'b0;
    logic [7:0]  e_waddr = '0, e_raddr = '0;
    logic [15:0] e_wdata = '0, e_mask = '0;

    function automatic req_t rd(input logic [7:0] a);
        rd = '{v: 1'b1, we: 1'b0, addr: a, wdata: 16'h0, mask_n: 16'h0};
    endfunction

    function automatic req_t wr(input logic [7:0] a, input logic [15:0] d, input logic [15:0] m);
        wr = '{v: 1'b1, we: 1'b1, addr: a, wdata: d, mask_n: m};
    endfunction

    function automatic req_t rnd_req();
        req_t r;
        r.v      = ($urandom_range(0, 9) < 7);
        r.we     = $urandom_range(0, 1);
        r.addr   = 8'($urandom_range(0, 15));
        r.wdata  = 16'($urandom);
        r.mask_n = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0000;
        return r;
    endfunction

    task automatic step(input req_t r0, input req_t r1, input bit cs, input bit rst);
        bit g0, g1, ev0, ev1, gid;
        logic [15:0] ed;
        req_t gr;
        #1;
        req0_valid = r0.v; req0_we = r0.we; req0_addr = r0.addr;
        req0_wdata = r0.wdata; req0_mask_n = r0.mask_n;
        req1_valid = r1.v; req1_we = r1.we; req1_addr = r1.addr;
        req1_wdata = r1.wdata; req1_mask_n = r1.mask_n;
        clear_start = cs;
        RST = rst;
        #1;
        g0 = 1'b0; g1 = 1'b0;
        if (!rst && !m_clear && !cs) begin
            if (r0.v && (!r1.v || !m_ptr)) g0 = 1'b1;
            else if (r1.v) g1 = 1'b1;
        end
        check("req0_ready", 32'(req0_ready), 32'(g0));
        check("req1_ready", 32'(req1_ready), 32'(g1));
        if (m_known) begin
            check("busy", 32'(busy), 32'(m_clear));
            check("ram_we", 32'(ram_we), 32'(e_we));
            check("ram_re", 32'(ram_re), 32'(e_re));
            if (e_we) begin
                check("ram_waddr", 32'(ram_waddr), 32'(e_waddr));
                check("ram_wdata", 32'(ram_wdata), 32'(e_wdata));
                check("ram_mask_n", 32'(ram_mask_n), 32'(e_mask));
            end
            if (e_re) check("ram_raddr", 32'(ram_raddr), 32'(e_raddr));
            if (e_zero) begin
                check("rst_waddr", 32'(ram_waddr), 32'h0);
                check("rst_raddr", 32'(ram_raddr), 32'h0);
                check("rst_wdata", 32'(ram_wdata), 32'h0);
                check("rst_mask_n", 32'(ram_mask_n), 32'h0);
            end
            ev0 = 1'b0; ev1 = 1'b0; ed = '0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                ev0 = !rq[0].id;
                ev1 = rq[0].id;
                ed  = rq[0].data;
                void'(rq.pop_front());
            end
            check("resp0_valid", 32'(resp0_valid), 32'(ev0));
            check("resp1_valid", 32'(resp1_valid), 32'(ev1));
            if (ev0) check("resp0_rdata", 32'(resp0_rdata), 32'(ed));
            if (ev1) check("resp1_rdata", 32'(resp1_rdata), 32'(ed));
        end
        // advance the reference model across the coming edge
        e_we = 1'b0; e_re = 1'b0; e_zero = 1'b0;
        if (rst) begin
            m_known = 1'b1;
            m_clear = CLR_RST;
            m_cnt   = '0;
            m_ptr   = 1'b0;
            e_zero  = 1'b1;
            while (rq.size() > 0 && rq[rq.size()-1].due > cyc) void'(rq.pop_back());
            if (CLR_RST) for (int i = 0; i < 256; i++) sh[i] = 16'h0000;
        end else if (m_clear) begin
            e_we = 1'b1; e_waddr = m_cnt; e_wdata = '0; e_mask = '0;
            if (m_cnt == 8'd255) m_clear = 1'b0;
            m_cnt = m_cnt + 8'd1;
        end else if (cs) begin
            m_clear = 1'b1;
            for (int i = 0; i < 256; i++) sh[i] = 16'h0000;
        end else if (g0 || g1) begin
            gr    = g0 ? r0 : r1;
            gid   = g1;
            m_ptr = g0;
            if (gr.we) begin
                e_we = 1'b1; e_waddr = gr.addr; e_wdata = gr.wdata; e_mask = gr.mask_n;
                sh[gr.addr] = (sh[gr.addr] & gr.mask_n) | (gr.wdata & ~gr.mask_n);
            end else begin
                e_re = 1'b1; e_raddr = gr.addr;
                rq.push_back('{due: cyc + 2, id: gid, data: sh[gr.addr]});
            end
        end
        @(posedge CLK);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, 1'b0, 1'b0);
    endtask

    task automatic drain_clear(input req_t r0, input req_t r1, input bit rnd);
        int guard;
        guard = 0;
        while (m_clear && guard < 300) begin
            if (rnd) step(rnd_req(), rnd_req(), 1'($urandom_range(0, 1)), 1'b0);
            else step(r0, r1, 1'b0, 1'b0);
            guard++;
        end
        check("clear_done", 32'(m_clear), 32'h0);
    endtask

    int busy_cnt;
    always @(negedge CLK) if (busy === 1'b1) busy_cnt++;

    initial begin
        for (int i = 0; i < 256; i++) sh[i] = 16'h0000;
        @(posedge CLK);
        for (int i = 0; i < 3; i++) step('0, '0, 1'b0, 1'b1);
        // sweep after reset, with requests and clear pulses that must be ignored
        busy_cnt = 0;
        drain_clear('0, '0, 1'b1);
        check("sweep_len", 32'(busy_cnt), 32'd256);
        step(rd(8'h7F), '0, 1'b0, 1'b0);
        idle(3);
        // write then immediate read of the same address
        step(wr(8'h12, 16'hBEEF, 16'h0000), '0, 1'b0, 1'b0);
        step(rd(8'h12), '0, 1'b0, 1'b0);
        idle(3);
        // seed 0x01/0x02, last grant to req1 leaves req0 with priority
        step(wr(8'h01, 16'h1111, 16'h0000), '0, 1'b0, 1'b0);
        step('0, wr(8'h02, 16'h2222, 16'h0000), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(rd(8'h01), rd(8'h02), 1'b0, 1'b0);
        idle(3);
        // masked write keeps the masked bits
        step(wr(8'h20, 16'hFFFF, 16'h0000), '0, 1'b0, 1'b0);
        step(wr(8'h20, 16'h0000, 16'hFF00), '0, 1'b0, 1'b0);
        step(rd(8'h20), '0, 1'b0, 1'b0);
        idle(3);
        // read followed by reset: response discarded, outputs zeroed
        step(rd(8'h20), '0, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b1);
        drain_clear('0, '0, 1'b0);
        step(rd(8'h01), rd(8'h02), 1'b0, 1'b0);
        idle(3);
        // clear_start while req1 waits
        step('0, rd(8'h02), 1'b1, 1'b0);
        busy_cnt = 0;
        drain_clear('0, rd(8'h02), 1'b0);
        check("cmd_sweep_len", 32'(busy_cnt), 32'd256);
        step('0, rd(8'h02), 1'b0, 1'b0);
        idle(3);
        // random traffic with occasional clears and resets
        for (int i = 0; i < 4000; i++) begin
            step(rnd_req(), rnd_req(), ($urandom_range(0, 299) == 0), ($urandom_range(0, 599) == 0));
        end
        idle(4);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ebr_arbiter.md
Name: ebr_arbiter

Overview:
- Two-port round-robin arbiter and sequencer that shares one 4 kbit EBR block RAM between two requesters.
- The EBR is configured in 16-bit mode: 256 x 16, with DATA_WIDTH_W = DATA_WIDTH_R = "16".
- The block serialises read and write requests, drives the EBR read and write ports, and returns read data to the requester that issued the read.
- An optional clear sequencer zero-fills the RAM after reset or on command.
- The block sits between client logic and a single EBR_B / SB_RAM40_4K instance.

Parameters:
- CLEAR_ON_RESET, 1: when 1, the block enters the CLEAR state after reset; when 0, it enters RUN.
- ADDR_W, 8: address width in words. Fixed at 8 for 16-bit mode; ram_*addr bits 10:8 are tied to 0 externally.

Ports:
- CLK  in  1  single clock; also drives the EBR RCLK and WCLK.
- RST  in  1  synchronous, active-high reset.
- clear_start  in  1  one-cycle pulse requesting a RAM zero-fill.
- busy  out  1  high while in the CLEAR state.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_we / req1_we  in  1  1 = write, 0 = read.
- req0_addr / req1_addr  in  8  word address.
- req0_wdata / req1_wdata  in  16  write data.
- req0_mask_n / req1_mask_n  in  16  per-bit write mask; 1 = bit not written.
- resp0_valid / resp1_valid  out  1  read data valid for that requester.
- resp0_rdata / resp1_rdata  out  16  read data.
- ram_raddr  out  8  to EBR RADDR.
- ram_waddr  out  8  to EBR WADDR.
- ram_wdata  out  16  to EBR WDATA.
- ram_mask_n  out  16  to EBR MASK_N.
- ram_re  out  1  to EBR RE; EBR RCLKE is tied to 1.
- ram_we  out  1  to EBR WE; EBR WCLKE is tied to 1.
- ram_rdata  in  16  from EBR RDATA.

Behaviour:
- Reset (RST high at a rising edge):
  - Registered outputs (ram_*, resp*_valid, the pointer, the clear counter) go to 0.
  - The round-robin pointer goes to 0, meaning requester 0 has priority.
  - The read pipeline flags are cleared.
  - State becomes CLEAR if CLEAR_ON_RESET=1, else RUN.
  - req*_ready is 0 in any cycle where RST=1.
- Reset mid-operation:
  - Any in-flight read is discarded; no resp_valid is produced for it.
  - A clear in progress restarts from address 0 when CLEAR_ON_RESET=1.
- State CLEAR:
  - busy=1 and req*_ready=0.
  - An 8-bit counter cnt starts at 0. Each cycle the block registers ram_we=1, ram_waddr=cnt, ram_wdata=0, ram_mask_n=0, then increments cnt.
  - When a write with cnt=255 is issued, the state becomes RUN and cnt wraps to 0.
  - The sweep takes exactly 256 cycles.
  - clear_start is ignored while in CLEAR.
- State RUN:
  - busy=0.
  - clear_start=1 moves the state to CLEAR on the next edge, and no request is granted in that cycle.
  - Reads already in flight still complete and return resp_valid.
- Arbitration (RUN only, combinational):
  - If exactly one reqN_valid is high, that requester is granted.
  - If both are high, the requester selected by the pointer is granted.
  - reqN_ready is 1 only for the granted requester.
  - After every grant the pointer is set to point at the non-granted requester, so it holds priority next time.
  - A lone valid requester is granted every cycle: no bubbles, throughput of 1 access per cycle.
  - Neither requester can be starved: under continuous contention the grants alternate 0,1,0,1.
- Issue timing:
  - A grant in cycle t registers ram_we/ram_re, the address, wdata and mask_n, which appear on the EBR in cycle t+1.
  - Only one of ram_we and ram_re is high in any cycle.
  - In cycles with no grant, ram_re=0 and ram_we=0. ram_mask_n/wdata/addr hold their last values.
- Read return:
  - The requester id is pipelined alongside the read.
  - The EBR samples in cycle t+1 and ram_rdata is valid in cycle t+2.
  - respN_valid is registered and high in cycle t+2 for the issuing requester.
  - respN_rdata = ram_rdata (combinational passthrough), valid only while respN_valid=1.
  - Read latency is 2 cycles from the accept cycle.
- Responses:
  - There is no response backpressure; requesters must always accept responses.
  - Back-to-back reads give back-to-back responses, in issue order.
- Ordering:
  - A write accepted in cycle t followed by a read of the same address accepted in t+1 returns the new data.
  - Masked bits retain their old value.
- Addresses are 8-bit; there is no wrap or overflow handling beyond natural 8-bit indexing.

Test Plan:
- Reset with CLEAR_ON_RESET=1 -> busy=1 for exactly 256 cycles with ram_we=1 and waddr sweeping 0..255, then busy=0. A subsequent read of addr 0x7F returns 0x0000.
- req0 writes 0xBEEF to 0x12 in cycle t; req0 reads 0x12 in cycle t+1 -> ram_re=1 in t+2, resp0_valid=1 in t+3 with rdata 0xBEEF, and resp1_valid stays 0.
- Both valid continuously, reads to 0x01 (req0) and 0x02 (req1) -> grants alternate 0,1,0,1 starting with req0. Responses alternate resp0/resp1, 2 cycles after each accept.
- Write 0xFFFF to 0x20, then write 0x0000 to 0x20 with mask_n=0xFF00 -> a read of 0x20 returns 0xFF00.
- Read accepted in cycle t, RST asserted in cycle t+1 -> no resp_valid in t+2, all ram_* outputs 0, and the pointer is back to req0.
- clear_start pulsed while req1_valid is held high -> no grant in that cycle, busy=1 for 256 cycles, then req1 is granted first in RUN.
